// File: rtl/riscv_pkg.sv
// Shared register-file constants and the writeback entry type used across the
// writeback path.
package riscv_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_load_fifo.sv
// Small synchronous FIFO buffering load results until they win the register
// write port. DEPTH must be a power of two so the pointers wrap naturally.
module writeback_load_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/register_writeback.sv
// Register-file writeback controller: arbitrates ALU and buffered load results
// onto the single write port and tracks pending destinations in a busy scoreboard.
module register_writeback #(
    parameter int DATA_WIDTH      = riscv_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH      = riscv_pkg::REG_ADDR_WIDTH,
    parameter int LOAD_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluRd,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  loadValid,
    input  logic [ADDR_WIDTH-1:0] loadRd,
    input  logic [DATA_WIDTH-1:0] loadData,
    output logic                  loadReady,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueRd,
    input  logic [ADDR_WIDTH-1:0] queryRs1,
    input  logic [ADDR_WIDTH-1:0] queryRs2,
    output logic                  busyRs1,
    output logic                  busyRs2,
    output logic                  rWrite,
    output logic [ADDR_WIDTH-1:0] rsWrite,
    output logic [DATA_WIDTH-1:0] dataWrite
);

    import riscv_pkg::*;

    localparam int NREGS   = 1 << ADDR_WIDTH;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] RD_ZERO = ADDR_WIDTH'(REG_ZERO);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_head;

    logic                  win_valid;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_writes;

    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_next;

    assign loadReady = !reset && !fifo_full;
    assign aluReady  = !reset && !fifo_full;
    assign fifo_push = loadValid && loadReady;

    writeback_load_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOAD_FIFO_DEPTH)
    ) u_load_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({loadRd, loadData}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A full FIFO preempts the ALU for one cycle so loads can never be starved.
    always_comb begin
        fifo_pop  = 1'b0;
        win_valid = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        if (!reset) begin
            if (fifo_full) begin
                fifo_pop  = 1'b1;
                win_valid = 1'b1;
                win_rd    = fifo_head[ENTRY_W-1:DATA_WIDTH];
                win_data  = fifo_head[DATA_WIDTH-1:0];
            end else if (aluValid) begin
                win_valid = 1'b1;
                win_rd    = aluRd;
                win_data  = aluData;
            end else if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                win_valid = 1'b1;
                win_rd    = fifo_head[ENTRY_W-1:DATA_WIDTH];
                win_data  = fifo_head[DATA_WIDTH-1:0];
            end
        end
    end

    assign win_writes = win_valid && (win_rd != RD_ZERO);

    // Set is applied after clear so a re-issue to the committing register stays busy.
    always_comb begin
        busy_next = busy;
        if (win_writes) begin
            busy_next[win_rd] = 1'b0;
        end
        if (issueValid && (issueRd != RD_ZERO)) begin
            busy_next[issueRd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rWrite    <= 1'b0;
            rsWrite   <= '0;
            dataWrite <= '0;
            busy      <= '0;
        end else begin
            rWrite <= win_writes;
            if (win_valid) begin
                rsWrite   <= win_rd;
                dataWrite <= win_data;
            end
            busy <= busy_next;
        end
    end

    assign busyRs1 = busy[queryRs1];
    assign busyRs2 = busy[queryRs2];

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: hand-computed expectations for reset,
// ALU/load arbitration, rd=0 handling and the busy scoreboard.
module tb_register_writeback;

    logic        clk;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        aluReady;
    logic        loadValid;
    logic [4:0]  loadRd;
    logic [31:0] loadData;
    logic        loadReady;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic [4:0]  queryRs1;
    logic [4:0]  queryRs2;
    logic        busyRs1;
    logic        busyRs2;
    logic        rWrite;
    logic [4:0]  rsWrite;
    logic [31:0] dataWrite;

    int total = 0;
    int bad   = 0;

    register_writeback #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (5),
        .LOAD_FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .aluValid   (aluValid),
        .aluRd      (aluRd),
        .aluData    (aluData),
        .aluReady   (aluReady),
        .loadValid  (loadValid),
        .loadRd     (loadRd),
        .loadData   (loadData),
        .loadReady  (loadReady),
        .issueValid (issueValid),
        .issueRd    (issueRd),
        .queryRs1   (queryRs1),
        .queryRs2   (queryRs2),
        .busyRs1    (busyRs1),
        .busyRs2    (busyRs2),
        .rWrite     (rWrite),
        .rsWrite    (rsWrite),
        .dataWrite  (dataWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        aluValid   = 1'b0;
        aluRd      = '0;
        aluData    = '0;
        loadValid  = 1'b0;
        loadRd     = '0;
        loadData   = '0;
        issueValid = 1'b0;
        issueRd    = '0;
        queryRs1   = '0;
        queryRs2   = '0;

        step();
        step();
        check("rst_rWrite",    rWrite,    0);
        check("rst_rsWrite",   rsWrite,   0);
        check("rst_dataWrite", dataWrite, 0);
        check("rst_aluReady",  aluReady,  0);
        check("rst_loadReady", loadReady, 0);
        reset = 1'b0;
        #1;
        check("post_rst_aluReady",  aluReady,  1);
        check("post_rst_loadReady", loadReady, 1);

        // ALU write, latency 1
        aluValid = 1'b1; aluRd = 5'd3; aluData = 32'h0000_0007;
        #1;
        check("alu3_ready", aluReady, 1);
        step();
        aluValid = 1'b0;
        check("alu3_rWrite",  rWrite,    1);
        check("alu3_rsWrite", rsWrite,   3);
        check("alu3_data",    dataWrite, 32'h7);
        step();
        check("idle_rWrite", rWrite, 0);

        // busy scoreboard on rd=5
        issueValid = 1'b1; issueRd = 5'd5; queryRs1 = 5'd5;
        #1;
        check("busy5_before", busyRs1, 0);
        step();
        issueValid = 1'b0;
        check("busy5_set", busyRs1, 1);
        step();
        check("busy5_hold", busyRs1, 1);
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h0000_00FC;
        step();
        aluValid = 1'b0;
        check("alu5_rWrite",  rWrite,    1);
        check("alu5_rsWrite", rsWrite,   5);
        check("alu5_data",    dataWrite, 32'hFC);
        check("busy5_clear",  busyRs1,   0);

        // rd=0 result: accepted, no write, busy[0] stays 0
        aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hFFFF_FFFF; queryRs2 = 5'd0;
        #1;
        check("alu0_ready", aluReady, 1);
        step();
        aluValid = 1'b0;
        check("alu0_rWrite", rWrite,    0);
        check("alu0_data",   dataWrite, 32'hFFFF_FFFF);
        check("busy0",       busyRs2,   0);

        // Two loads while ALU stays valid: FIFO fills, load head preempts once
        aluValid = 1'b1; aluRd = 5'd7; aluData = 32'hA1;
        loadValid = 1'b1; loadRd = 5'd1; loadData = 32'h11;
        #1;
        check("fill_aluReady_a",  aluReady,  1);
        check("fill_loadReady_a", loadReady, 1);
        step();
        check("fill_a_rsWrite", rsWrite,   7);
        check("fill_a_data",    dataWrite, 32'hA1);
        aluData = 32'hA2; loadRd = 5'd2; loadData = 32'h22;
        step();
        loadValid = 1'b0; aluData = 32'hA3;
        check("fill_b_data",     dataWrite, 32'hA2);
        check("full_loadReady",  loadReady, 0);
        check("full_aluReady",   aluReady,  0);
        step();
        check("pop1_rWrite",   rWrite,    1);
        check("pop1_rsWrite",  rsWrite,   1);
        check("pop1_data",     dataWrite, 32'h11);
        check("pop1_aluReady", aluReady,  1);
        step();
        aluValid = 1'b0;
        check("alu7_rsWrite", rsWrite,   7);
        check("alu7_data",    dataWrite, 32'hA3);
        step();
        check("pop2_rWrite",  rWrite,    1);
        check("pop2_rsWrite", rsWrite,   2);
        check("pop2_data",    dataWrite, 32'h22);
        step();
        check("drained_rWrite", rWrite, 0);

        // Set beats clear on the same register in one cycle
        aluValid = 1'b1; aluRd = 5'd4; aluData = 32'h44;
        issueValid = 1'b1; issueRd = 5'd4; queryRs1 = 5'd4;
        step();
        issueValid = 1'b0;
        check("same4_rWrite",  rWrite,  1);
        check("same4_rsWrite", rsWrite, 4);
        check("same4_busy",    busyRs1, 1);
        step();
        aluValid = 1'b0;
        check("clear4_busy", busyRs1, 0);

        // Reset with a full FIFO discards the buffered loads and the scoreboard
        aluValid = 1'b1; aluRd = 5'd10; aluData = 32'hB0;
        loadValid = 1'b1; loadRd = 5'd8; loadData = 32'h88;
        issueValid = 1'b1; issueRd = 5'd6; queryRs2 = 5'd6;
        step();
        issueValid = 1'b0; aluData = 32'hB1; loadRd = 5'd9; loadData = 32'h99;
        step();
        loadValid = 1'b0; aluValid = 1'b0;
        check("prerst_full_loadReady", loadReady, 0);
        check("prerst_busy6",          busyRs2,   1);
        reset = 1'b1;
        #1;
        check("inrst_aluReady", aluReady, 0);
        step();
        reset = 1'b0;
        #1;
        check("rst2_rWrite",    rWrite,    0);
        check("rst2_busy6",     busyRs2,   0);
        check("rst2_loadReady", loadReady, 1);
        check("rst2_aluReady",  aluReady,  1);
        step();
        check("rst2_nowrite_a", rWrite, 0);
        step();
        check("rst2_nowrite_b", rWrite, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
